// File: rtl/addsub_pipe.sv
// Pipelined add/sub/rsub/cmp unit; the carry chain is split into STAGES registered chunks.
// Flags are resolved in the last stage, with optional saturation on overflow.
module addsub_chunk #(
  parameter int C = 8
) (
  input  logic [C-1:0] a_i,
  input  logic [C-1:0] b_i,
  input  logic         cin_i,
  output logic [C-1:0] sum_o,
  output logic         cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{C{1'b0}}, cin_i};
endmodule

module addsub_pipe #(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  localparam int C = WIDTH / STAGES;

  logic              en;
  logic [STAGES:1]   vld_pipe;
  logic [WIDTH-1:0]  ex, ey;
  logic              cin;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // Every subtraction form becomes X + ~Y + 1
  always_comb begin
    ex  = in1;
    ey  = ~in2;
    cin = 1'b1;
    case (op)
      2'b00:   begin ey = in2; cin = 1'b0; end
      2'b10:   begin ex = in2; ey = ~in1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO = s * C;
    localparam int RW = WIDTH - LO;

    logic [RW-1:0]   x_i, y_i;
    logic            c_i, sg_i;
    logic [1:0]      op_i;
    logic [C-1:0]    sum;
    logic            cout;
    logic [LO+C-1:0] r_new;

    if (s == 0) begin : g_in
      assign x_i   = ex;
      assign y_i   = ey;
      assign c_i   = cin;
      assign op_i  = op;
      assign sg_i  = is_signed;
      assign r_new = sum;
    end else begin : g_fwd
      assign x_i   = g_stg[s-1].g_mid.x_q;
      assign y_i   = g_stg[s-1].g_mid.y_q;
      assign c_i   = g_stg[s-1].g_mid.c_q;
      assign op_i  = g_stg[s-1].g_mid.op_q;
      assign sg_i  = g_stg[s-1].g_mid.sg_q;
      assign r_new = {sum, g_stg[s-1].g_mid.r_q};
    end

    addsub_chunk #(.C(C)) u_chunk (
      .a_i    (x_i[C-1:0]),
      .b_i    (y_i[C-1:0]),
      .cin_i  (c_i),
      .sum_o  (sum),
      .cout_o (cout)
    );

    if (s < STAGES - 1) begin : g_mid
      // Only the not-yet-added upper operand bits travel on
      logic [RW-C-1:0] x_q, y_q;
      logic [LO+C-1:0] r_q;
      logic            c_q, sg_q;
      logic [1:0]      op_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0; y_q <= '0; r_q <= '0;
          c_q <= 1'b0; sg_q <= 1'b0; op_q <= 2'b00;
        end else if (en) begin
          x_q  <= x_i[RW-1:C];
          y_q  <= y_i[RW-1:C];
          r_q  <= r_new;
          c_q  <= cout;
          sg_q <= sg_i;
          op_q <= op_i;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] raw, res;
      logic             bor, cy, xs, ys, sovf, ov, zf, nf;

      always_comb begin
        raw  = r_new;
        bor  = (op_i != 2'b00);
        cy   = bor ? ~cout : cout;
        xs   = x_i[C-1];
        ys   = y_i[C-1];
        sovf = (xs == ys) && (raw[WIDTH-1] != xs);
        ov   = sg_i ? sovf : cy;
        res  = raw;
        if (op_i == 2'b11) begin
          res = '0;
        end else if ((SATURATE != 0) && ov) begin
          if (sg_i) res = xs ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          else      res = bor ? '0 : '1;
        end
        // cmp reports flags of A-B even though its result is forced to 0
        zf = (op_i == 2'b11) ? (raw == '0) : (res == '0);
        nf = (op_i == 2'b11) ? raw[WIDTH-1] : res[WIDTH-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result <= '0; carry <= 1'b0; zero <= 1'b0; neg <= 1'b0; ovf <= 1'b0;
        end else if (en) begin
          result <= res;
          carry  <= cy;
          zero   <= zf;
          neg    <= nf;
          ovf    <= ov;
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: a wrapping and a saturating instance share one stimulus stream.
module tb_addsub_pipe;
  localparam int W = 16;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, is_signed = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic         in_ready, out_valid, carry, zero, neg, ovf;
  logic [W-1:0] result;
  logic         s_in_ready, s_out_valid, s_carry, s_zero, s_neg, s_ovf;
  logic [W-1:0] s_result;
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .STAGES(2), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero), .neg(neg), .ovf(ovf)
  );

  addsub_pipe #(.WIDTH(W), .STAGES(2), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in1(in1), .in2(in2), .op(op), .is_signed(is_signed),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result),
    .carry(s_carry), .zero(s_zero), .neg(s_neg), .ovf(s_ovf)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sg);
    in_valid = 1'b1; op = o; in1 = a; in2 = b; is_signed = sg;
  endtask

  // One beat, then sample two cycles after acceptance
  task automatic single(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sg);
    drive(o, a, b, sg);
    step();
    in_valid = 1'b0;
    chk({tag, ".early"}, out_valid, 1'b0);
    step();
    chk({tag, ".ovalid"}, out_valid, 1'b1);
  endtask

  task automatic flags(input string tag, input logic [W-1:0] r, input logic c, input logic z,
                       input logic n, input logic o);
    chk({tag, ".res"}, result, r);
    chk({tag, ".carry"}, carry, c);
    chk({tag, ".zero"}, zero, z);
    chk({tag, ".neg"}, neg, n);
    chk({tag, ".ovf"}, ovf, o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst.ovalid", out_valid, 1'b0);
    chk("rst.res", result, 16'h0000);
    chk("rst.zero", zero, 1'b0);
    chk("rst.inready", in_ready, 1'b1);
    chk("rst.inready_sat", s_in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    single("sub2_3", 2'b01, 16'd2, 16'd3, 1'b0);
    flags("sub2_3", 16'hFFFF, 1, 0, 1, 1);
    chk("sub2_3.sat_res", s_result, 16'h0000);
    chk("sub2_3.sat_zero", s_zero, 1'b1);

    single("sub15_15", 2'b01, 16'd15, 16'd15, 1'b0);
    flags("sub15_15", 16'h0000, 0, 1, 0, 0);

    single("cmp", 2'b11, 16'd1500, 16'd2500, 1'b1);
    flags("cmp", 16'h0000, 1, 0, 1, 0);
    chk("cmp.sat_res", s_result, 16'h0000);

    single("add00ff", 2'b00, 16'h00FF, 16'h0001, 1'b0);
    flags("add00ff", 16'h0100, 0, 0, 0, 0);

    single("addffff", 2'b00, 16'hFFFF, 16'h0001, 1'b0);
    flags("addffff", 16'h0000, 1, 1, 0, 1);
    chk("addffff.sat_res", s_result, 16'hFFFF);
    chk("addffff.sat_zero", s_zero, 1'b0);
    chk("addffff.sat_carry", s_carry, 1'b1);

    single("sadd7fff", 2'b00, 16'h7FFF, 16'h0001, 1'b1);
    flags("sadd7fff", 16'h8000, 0, 0, 1, 1);
    chk("sadd7fff.sat_res", s_result, 16'h7FFF);
    chk("sadd7fff.sat_ovf", s_ovf, 1'b1);
    chk("sadd7fff.sat_neg", s_neg, 1'b0);

    single("ssub8000", 2'b01, 16'h8000, 16'h0001, 1'b1);
    flags("ssub8000", 16'h7FFF, 0, 0, 0, 1);
    chk("ssub8000.sat_res", s_result, 16'h8000);
    chk("ssub8000.sat_neg", s_neg, 1'b1);
    chk("ssub8000.sat_valid", s_out_valid, 1'b1);

    single("rsub3_10", 2'b10, 16'd3, 16'd10, 1'b0);
    flags("rsub3_10", 16'd7, 0, 0, 0, 0);
    single("rsub10_3", 2'b10, 16'd10, 16'd3, 1'b0);
    flags("rsub10_3", 16'hFFF9, 1, 0, 1, 1);

    // Backpressure: three stalled edges with the first result waiting
    drive(2'b01, 16'd2500, 16'd1500, 1'b0);
    step();
    drive(2'b01, 16'd10, 16'd60, 1'b0);
    step();
    chk("bp.first_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    drive(2'b01, 16'd6, 16'd2, 1'b0);
    #1;
    chk("bp.inready_stall", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.stall_res", result, 16'd1000);
      chk("bp.stall_valid", out_valid, 1'b1);
      chk("bp.stall_inready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_inready", in_ready, 1'b1);
    chk("bp.beat0", result, 16'd1000);
    step();
    in_valid = 1'b0;
    chk("bp.beat1_valid", out_valid, 1'b1);
    chk("bp.beat1", result, 16'hFFCE);
    step();
    chk("bp.beat2_valid", out_valid, 1'b1);
    chk("bp.beat2", result, 16'd4);
    step();
    chk("bp.drained", out_valid, 1'b0);

    // Reset mid-stream with one beat at the output and one in flight
    drive(2'b01, 16'd2500, 16'd1500, 1'b0);
    step();
    drive(2'b01, 16'd6, 16'd2, 1'b0);
    step();
    in_valid = 1'b0;
    chk("mrst.pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.ovalid", out_valid, 1'b0);
    chk("mrst.res", result, 16'h0000);
    chk("mrst.inready", in_ready, 1'b1);
    step();
    step();
    #2 rst_n = 1'b1;
    drive(2'b01, 16'd10, 16'd10, 1'b0);
    step();
    in_valid = 1'b0;
    chk("mrst.no_stale", out_valid, 1'b0);
    step();
    chk("mrst.new_valid", out_valid, 1'b1);
    chk("mrst.new_res", result, 16'h0000);
    chk("mrst.new_zero", zero, 1'b1);
    step();
    chk("mrst.drained", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined integer add/subtract unit with valid/ready handshakes, an operation select, status flags and optional saturation. It is the registered successor to the team's fixed 16-bit combinational subtractor. It sits between the register-read and write-back stages of the CPU datapath. The carry chain is split into STAGES registered chunks so the block can close timing at wider WIDTH.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES.
- STAGES, 2, pipeline depth; each stage resolves WIDTH/STAGES bits. Range 1..WIDTH.
- SATURATE, 0, 1 = clamp result on overflow; 0 = wrap.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- op  in  2  00 add A+B; 01 sub A-B; 10 rsub B-A; 11 cmp (flags of A-B, result forced 0).
- is_signed  in  1  two's-complement interpretation for ovf and saturation.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  sum or difference.
- carry  out  1  add: carry-out; sub/rsub/cmp: borrow (1 when minuend < subtrahend, unsigned).
- zero  out  1  result == 0; for cmp, set when A == B.
- neg  out  1  MSB of the result; for cmp, MSB of A-B.
- ovf  out  1  add/sub overflow: signed overflow if is_signed, otherwise the carry/borrow.

## Operation
- Subtraction is computed as X + ~Y + 1. Add/sub/rsub select the operand order and the inversion. The carry-in to chunk 0 is 1 for subtraction forms and 0 for add.
- Stage k adds chunk k (bits k*C..k*C+C-1, where C = WIDTH/STAGES) with the registered carry from stage k-1.
- Upper chunks and control (op, is_signed, operand MSBs) are delayed alongside the data.
- Lower result chunks already computed are carried forward in registers.
- Final stage:
  - Assembles the raw result.
  - carry = raw carry-out for add, and the inverted carry-out for the subtraction forms.
  - Signed ovf: the operands of the effective addition have the same sign and the raw result sign differs.
- Saturation (SATURATE=1, ovf=1):
  - Unsigned add → all ones; unsigned sub/rsub → 0.
  - Signed: positive overflow → 0111..1; negative overflow → 1000..0. The direction is taken from the sign of the effective first operand.
- zero and neg are taken from the final (post-saturation) result. carry and ovf describe the raw operation.
- cmp: result = 0; zero, neg, carry and ovf are those of A-B; no saturation.

## Timing
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+STAGES when there is no stall.
- Throughput: one beat per cycle.
- Global advance enable en = !out_valid || out_ready.
  - in_ready = en.
  - When en=0 all stage registers hold, and result and flags stay stable.
  - Bubbles are not collapsed.
- Input transfer: in_valid && in_ready. A stage valid bit loads 0 when en=1 and there is no transfer.
- Output transfer: out_valid && out_ready. Beats leave strictly in acceptance order; none are lost or duplicated.
- Reset (rst_n low, any time, including mid-stream):
  - Immediately clears all stage valid bits, out_valid, result, carry, zero, neg and ovf to 0.
  - In-flight beats are discarded.
  - in_ready reads 1 during reset, but no beat is captured until the first rising edge after rst_n deasserts.
- Simultaneous output transfer and input transfer in the same cycle is legal and sustains full rate.
- STAGES=1: a single registered stage with latency 1.

## Test plan
- WIDTH=16, STAGES=2, unsigned op=01, in1=2, in2=3 → two cycles later result=0xFFFF, carry=1, neg=1, zero=0, ovf=1.
- op=01, 15-15 → result=0, zero=1, carry=0. op=11, in1=1500, in2=2500, is_signed=1 → result=0, neg=1, carry=1, ovf=0, zero=0.
- Chunk boundary: op=00, 0x00FF+0x0001 → 0x0100. 0xFFFF+0x0001 → result=0, carry=1, zero=1.
- Signed op=00, 0x7FFF+0x0001: SATURATE=0 → 0x8000 with ovf=1; SATURATE=1 → 0x7FFF with ovf=1. Signed 0x8000-0x0001 with SATURATE=1 → 0x8000, ovf=1.
- Backpressure: stream 2500-1500, 10-60, 6-2 with out_ready held low for 3 cycles after the first out_valid.
  - Required: result=1000 stays stable and in_ready=0 during the stall.
  - Then 1000, 0xFFCE and 4 are delivered in order, with no loss.
- Reset mid-stream: assert rst_n low while out_valid=1 with a second beat in flight → out_valid=0 and result=0 without waiting for a clock edge. After release, the first new beat 10-10 appears with zero=1 exactly STAGES cycles after acceptance.
